// File: rtl/mat_row_loader.sv
// mat_row_loader: streams a WIDTH x WIDTH matrix from an element-addressed memory into one
// MatCache slot, one full row write per cycle, optionally tagged as column writes (transpose).
package mat_row_loader_pkg;
    typedef enum logic [1:0] {
        MAT_DATA_WRITE_NONE = 2'd0,
        MAT_DATA_WRITE_ROW  = 2'd1,
        MAT_DATA_WRITE_COL  = 2'd2
    } MatDataWriteOp_t;

    // IEEE-754 single-precision bit pattern; this is how shortreal elements travel in hardware
    typedef logic [31:0] shortreal_bits_t;
endpackage

module mat_row_loader
    import mat_row_loader_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CACHE_SIZE = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(CACHE_SIZE)-1:0] cmd_slot,
    input  logic [ADDR_WIDTH-1:0]         cmd_base,
    input  logic [ADDR_WIDTH-1:0]         cmd_stride,
    input  logic                          cmd_transpose,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr,
    input  logic                          mem_resp_valid,
    input  shortreal_bits_t               mem_resp_data,
    output MatDataWriteOp_t               write_op,
    output logic [$clog2(CACHE_SIZE)-1:0] write_addr1,
    output logic [$clog2(WIDTH)-1:0]      write_param,
    output shortreal_bits_t [WIDTH-1:0]   data_in,
    output logic                          done
);
    localparam int SLOT_W = $clog2(CACHE_SIZE);
    localparam int IDX_W  = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state;
    state_t state_next;

    logic [SLOT_W-1:0]           slot_q;
    logic [ADDR_WIDTH-1:0]       stride_q;
    logic [ADDR_WIDTH-1:0]       row_addr;
    logic                        transpose_q;
    logic [IDX_W-1:0]            req_col;
    logic [IDX_W-1:0]            req_row;
    logic [IDX_W-1:0]            resp_col;
    logic [IDX_W-1:0]            resp_row;
    shortreal_bits_t [WIDTH-1:0] row_buf;
    shortreal_bits_t [WIDTH-1:0] row_full;

    logic accept;
    logic req_fire;
    logic last_req;
    logic resp_fire;
    logic row_end;
    logic last_resp;

    assign accept    = cmd_valid && cmd_ready;
    assign req_fire  = mem_req_valid && mem_req_ready;
    assign last_req  = req_fire && (req_row == LAST_IDX) && (req_col == LAST_IDX);
    // Responses arriving while idle are stray (e.g. in flight across a reset) and are dropped
    assign resp_fire = mem_resp_valid && (state != IDLE);
    assign row_end   = resp_fire && (resp_col == LAST_IDX);
    assign last_resp = row_end && (resp_row == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = ISSUE;
            ISSUE:   if (last_req)  state_next = DRAIN;
            DRAIN:   if (last_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        case (state)
            IDLE:  cmd_ready = !reset;
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = row_addr + ADDR_WIDTH'(req_col);
            end
            default: ;
        endcase
    end

    // The last element of a row bypasses the buffer so the row is written without an extra cycle
    always_comb begin
        row_full           = row_buf;
        row_full[LAST_IDX] = mem_resp_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q      <= '0;
            stride_q    <= '0;
            row_addr    <= '0;
            transpose_q <= 1'b0;
            req_col     <= '0;
            req_row     <= '0;
            resp_col    <= '0;
            resp_row    <= '0;
            row_buf     <= '0;
            data_in     <= '0;
            write_op    <= MAT_DATA_WRITE_NONE;
            write_addr1 <= '0;
            write_param <= '0;
            done        <= 1'b0;
        end else begin
            write_op <= MAT_DATA_WRITE_NONE;
            done     <= 1'b0;
            if (accept) begin
                slot_q      <= cmd_slot;
                stride_q    <= cmd_stride;
                transpose_q <= cmd_transpose;
                row_addr    <= cmd_base;
                req_col     <= '0;
                req_row     <= '0;
                resp_col    <= '0;
                resp_row    <= '0;
            end
            if (req_fire) begin
                if (req_col == LAST_IDX) begin
                    req_col  <= '0;
                    req_row  <= req_row + 1'b1;
                    row_addr <= row_addr + stride_q;
                end else begin
                    req_col <= req_col + 1'b1;
                end
            end
            if (resp_fire) begin
                row_buf[resp_col] <= mem_resp_data;
                if (row_end) begin
                    data_in     <= row_full;
                    write_op    <= transpose_q ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
                    write_param <= resp_row;
                    write_addr1 <= slot_q;
                    resp_col    <= '0;
                    resp_row    <= resp_row + 1'b1;
                    done        <= last_resp;
                end else begin
                    resp_col <= resp_col + 1'b1;
                end
            end
        end
    end
endmodule
